// File: rtl/mips32_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// Operands are reduced to magnitudes, iterated one bit per cycle, then sign-corrected.
module mips32_muldiv #(
    parameter int DATAWIDTH = 32,
    parameter int WIDTH     = $clog2(DATAWIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           MD_op,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] A_in,
    input  logic [DATAWIDTH-1:0] B_in,
    output logic                 busy,
    output logic                 done,
    output logic                 Div_zero,
    output logic [DATAWIDTH-1:0] HI_out,
    output logic [DATAWIDTH-1:0] LO_out
);

    localparam int W = DATAWIDTH;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [W-1:0]     opB_q, opB_d;
    logic             isDiv_q, isDiv_d;
    logic             negRes_q, negRes_d;
    logic             negRem_q, negRem_d;
    logic [W-1:0]     hi_q, hi_d;
    logic [W-1:0]     lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             divZero_q, divZero_d;

    logic             signedOp;
    logic             aNeg;
    logic             bNeg;
    logic [W-1:0]     absA;
    logic [W-1:0]     absB;
    logic [W:0]       addSum;
    logic [2*W-1:0]   mulNext;
    logic [W:0]       remShift;
    logic [W:0]       diff;
    logic [2*W-1:0]   divNext;
    logic [W-1:0]     quoRaw;
    logic [W-1:0]     remRaw;
    logic [W-1:0]     quoFix;
    logic [W-1:0]     remFix;
    logic [2*W-1:0]   prodFix;

    // Magnitude of 0x80000000 is 2^31, which still fits unsigned in W bits.
    assign signedOp = ~MD_op[0];
    assign aNeg     = signedOp & A_in[W-1];
    assign bNeg     = signedOp & B_in[W-1];
    assign absA     = aNeg ? -A_in : A_in;
    assign absB     = bNeg ? -B_in : B_in;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    assign addSum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opB_q} : {(W+1){1'b0}});
    assign mulNext = {addSum, acc_q[W-1:1]};

    // Divide: acc = {partial remainder, dividend shifting into quotient}.
    assign remShift = acc_q[2*W-1:W-1];
    assign diff     = remShift - {1'b0, opB_q};
    assign divNext  = diff[W] ? {remShift[W-1:0], acc_q[W-2:0], 1'b0}
                              : {diff[W-1:0],     acc_q[W-2:0], 1'b1};

    assign quoRaw  = acc_q[W-1:0];
    assign remRaw  = acc_q[2*W-1:W];
    assign quoFix  = negRes_q ? -quoRaw : quoRaw;
    assign remFix  = negRem_q ? -remRaw : remRaw;
    assign prodFix = negRes_q ? -acc_q : acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opB_q     <= '0;
            isDiv_q   <= 1'b0;
            negRes_q  <= 1'b0;
            negRem_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divZero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opB_q     <= opB_d;
            isDiv_q   <= isDiv_d;
            negRes_q  <= negRes_d;
            negRem_q  <= negRem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            divZero_q <= divZero_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opB_d     = opB_q;
        isDiv_d   = isDiv_q;
        negRes_d  = negRes_q;
        negRem_d  = negRem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        divZero_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (MD_op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            // A zero divisor finishes immediately and leaves HI/LO alone.
                            if (MD_op[1] && (B_in == '0)) begin
                                done_d    = 1'b1;
                                divZero_d = 1'b1;
                            end else begin
                                isDiv_d  = MD_op[1];
                                negRes_d = aNeg ^ bNeg;
                                negRem_d = aNeg;
                                opB_d    = absB;
                                acc_d    = {{W{1'b0}}, absA};
                                cnt_d    = '0;
                                busy_d   = 1'b1;
                                state_d  = RUN;
                            end
                        end
                        3'd4:    hi_d = A_in;
                        3'd5:    lo_d = A_in;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                acc_d = isDiv_q ? divNext : mulNext;
                cnt_d = cnt_q + WIDTH'(1);
                if (cnt_q == WIDTH'(W - 1)) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end
            end
            FIX: begin
                if (isDiv_q) begin
                    lo_d = quoFix;
                    hi_d = remFix;
                end else begin
                    hi_d = prodFix[2*W-1:W];
                    lo_d = prodFix[W-1:0];
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign Div_zero = divZero_q;
    assign HI_out   = hi_q;
    assign LO_out   = lo_q;

endmodule

// File: tb/tb_mips32_muldiv.sv
// Scoreboard bench for mips32_muldiv: stimulus queues expected HI/LO/Div_zero,
// a negedge monitor pops and compares whenever done is presented.
module tb_mips32_muldiv;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  MD_op;
    logic        start;
    logic [31:0] A_in;
    logic [31:0] B_in;
    logic        busy;
    logic        done;
    logic        Div_zero;
    logic [31:0] HI_out;
    logic [31:0] LO_out;

    exp_t expQ[$];
    int   compareCount  = 0;
    int   mismatchCount = 0;

    mips32_muldiv #(.DATAWIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .MD_op    (MD_op),
        .start    (start),
        .A_in     (A_in),
        .B_in     (B_in),
        .busy     (busy),
        .done     (done),
        .Div_zero (Div_zero),
        .HI_out   (HI_out),
        .LO_out   (LO_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drives one request for a single cycle; returns #1 into the cycle after it.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        MD_op = op;
        A_in  = a;
        B_in  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pushExpected(input logic [31:0] hi, input logic [31:0] lo, input logic dz);
        exp_t e;
        e.hi = hi;
        e.lo = lo;
        e.dz = dz;
        expQ.push_back(e);
    endtask

    task automatic waitDone(input string name);
        int n = 0;
        while (!done && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({name, " done seen"}, {31'b0, done}, 32'd1);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (expQ.size() == 0) begin
                    compareCount++;
                    mismatchCount++;
                    $display("[TB] FAIL unexpected done: got done=1 with HI=0x%08h LO=0x%08h, required no completion", HI_out, LO_out);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("result HI", HI_out, e.hi);
                    checkOutput("result LO", LO_out, e.lo);
                    checkOutput("result Div_zero", {31'b0, Div_zero}, {31'b0, e.dz});
                    checkOutput("busy with done", {31'b0, busy}, 32'd0);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        MD_op = 3'd0;
        A_in  = '0;
        B_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset HI", HI_out, 32'h0);
        checkOutput("reset LO", LO_out, 32'h0);
        checkOutput("reset busy", {31'b0, busy}, 32'd0);
        checkOutput("reset done", {31'b0, done}, 32'd0);
        checkOutput("reset Div_zero", {31'b0, Div_zero}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // MULTU with exact cycle-by-cycle handshake checks.
        pushExpected(32'hFFFFFFFE, 32'h00000001, 1'b0);
        applyStimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        checkOutput("T1 busy N+1", {31'b0, busy}, 32'd1);
        checkOutput("T1 done N+1", {31'b0, done}, 32'd0);
        checkOutput("T1 HI held in RUN", HI_out, 32'h0);
        repeat (32) begin
            @(posedge clk);
            #1;
        end
        checkOutput("T1 busy N+33", {31'b0, busy}, 32'd1);
        checkOutput("T1 done N+33", {31'b0, done}, 32'd0);
        checkOutput("T1 LO held in FIX", LO_out, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("T1 done N+34", {31'b0, done}, 32'd1);
        checkOutput("T1 busy N+34", {31'b0, busy}, 32'd0);

        // Back-to-back starts issued in the done cycle.
        pushExpected(32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        applyStimulus(3'd0, 32'hFFFFFFFD, 32'd5);
        waitDone("MULT -3*5");
        pushExpected(32'h40000000, 32'h00000000, 1'b0);
        applyStimulus(3'd0, 32'h80000000, 32'h80000000);
        waitDone("MULT min*min");
        pushExpected(32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        applyStimulus(3'd2, 32'hFFFFFFF9, 32'd2);
        waitDone("DIV -7/2");
        pushExpected(32'd1, 32'd3, 1'b0);
        applyStimulus(3'd3, 32'd7, 32'd2);
        waitDone("DIVU 7/2");
        pushExpected(32'd1, 32'hFFFFFFFD, 1'b0);
        applyStimulus(3'd2, 32'd7, 32'hFFFFFFFE);
        waitDone("DIV 7/-2");
        pushExpected(32'h0000000F, 32'h0FFFFFFF, 1'b0);
        applyStimulus(3'd3, 32'hFFFFFFFF, 32'h00000010);
        waitDone("DIVU max/16");
        pushExpected(32'h00000000, 32'h80000000, 1'b0);
        applyStimulus(3'd2, 32'h80000000, 32'hFFFFFFFF);
        waitDone("DIV overflow");

        @(posedge clk);
        #1;
        applyStimulus(3'd6, 32'hDEADBEEF, 32'h0000BEEF);
        checkOutput("reserved busy", {31'b0, busy}, 32'd0);
        checkOutput("reserved done", {31'b0, done}, 32'd0);
        checkOutput("reserved HI", HI_out, 32'h0);
        checkOutput("reserved LO", LO_out, 32'h80000000);

        // MTHI/MTLO preload, then divide by zero.
        applyStimulus(3'd4, 32'h00001234, 32'h0);
        checkOutput("MTHI HI", HI_out, 32'h00001234);
        checkOutput("MTHI busy", {31'b0, busy}, 32'd0);
        checkOutput("MTHI done", {31'b0, done}, 32'd0);
        applyStimulus(3'd5, 32'h00005678, 32'h0);
        checkOutput("MTLO LO", LO_out, 32'h00005678);
        pushExpected(32'h00001234, 32'h00005678, 1'b1);
        applyStimulus(3'd3, 32'd9, 32'd0);
        checkOutput("div0 done N+1", {31'b0, done}, 32'd1);
        checkOutput("div0 Div_zero N+1", {31'b0, Div_zero}, 32'd1);
        checkOutput("div0 busy N+1", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("div0 busy N+2", {31'b0, busy}, 32'd0);
        checkOutput("div0 Div_zero N+2", {31'b0, Div_zero}, 32'd0);

        // MULT in flight ignores a start, then is killed by reset.
        applyStimulus(3'd0, 32'd3, 32'd4);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        applyStimulus(3'd5, 32'h000000AA, 32'h0);
        checkOutput("busy MTLO ignored", LO_out, 32'h00005678);
        checkOutput("busy still set", {31'b0, busy}, 32'd1);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("async reset HI", HI_out, 32'h0);
        checkOutput("async reset LO", LO_out, 32'h0);
        checkOutput("async reset busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        pushExpected(32'd1, 32'd3, 1'b0);
        applyStimulus(3'd3, 32'd10, 32'd3);
        waitDone("DIVU 10/3 after reset");

        repeat (40) begin
            @(posedge clk);
            #1;
        end
        checkOutput("scoreboard drained", expQ.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
